// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing a single FIFO write port among N_REQ producers.
// Bounded bursts per owner; writes are throttled so a full FIFO is never written.
module fifo_wr_arbiter #(
    parameter int N_REQ      = 4,
    parameter int FIFO_WIDTH = 16,
    parameter int MAX_BURST  = 4,
    localparam int IDX_W     = $clog2(N_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_REQ-1:0]              req,
    input  logic [N_REQ*FIFO_WIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]              gnt,
    input  logic                          fifo_full,
    input  logic                          fifo_almostfull,
    input  logic                          fifo_overflow,
    output logic                          fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]         fifo_data_in,
    output logic [IDX_W-1:0]              owner,
    output logic                          ovf_err
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic                   wr_en_q, wr_en_d;
    logic [FIFO_WIDTH-1:0]  data_q, data_d;
    logic                   ovf_q, ovf_d;

    logic                   can_write;
    logic                   idle_hit;
    logic [IDX_W-1:0]       idle_idx;
    logic [IDX_W-1:0]       win_idx;
    logic                   transfer;
    logic [FIFO_WIDTH-1:0]  req_word [N_REQ];

    function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) begin
            s = s - N_REQ;
        end
        return IDX_W'(s);
    endfunction

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign req_word[gi] = req_data[gi*FIFO_WIDTH +: FIFO_WIDTH];
    end

    // A write already sitting in the output register consumes the last free entry.
    assign can_write = !fifo_full && !(wr_en_q && fifo_almostfull);

    always_comb begin
        idle_hit = 1'b0;
        idle_idx = ptr_q;
        for (int k = 0; k < N_REQ; k++) begin
            if (!idle_hit && req[rr_index(ptr_q, k)]) begin
                idle_hit = 1'b1;
                idle_idx = rr_index(ptr_q, k);
            end
        end
    end

    always_comb begin
        gnt     = '0;
        win_idx = idle_idx;
        if (!rst_n && can_write) begin
            if (state_q == BURST) begin
                win_idx      = owner_q;
                gnt[owner_q] = req[owner_q];
            end else if (idle_hit) begin
                gnt[idle_idx] = 1'b1;
            end
        end
    end

    assign transfer = |(gnt & req);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        wr_en_d = transfer;
        data_d  = data_q;
        ovf_d   = ovf_q | fifo_overflow;

        if (transfer) begin
            data_d  = req_word[win_idx];
            ptr_d   = rr_index(win_idx, 1);
            owner_d = win_idx;
        end

        if (state_q == IDLE) begin
            if (transfer && (MAX_BURST > 1)) begin
                state_d = BURST;
                cnt_d   = CNT_W'(1);
            end
        end else begin
            // Owner withdrawing ends the burst; a stall (req held, no space) keeps it.
            if (!req[owner_q]) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else if (transfer) begin
                if (int'(cnt_q) + 1 == MAX_BURST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // rst_n keeps its historical name but is an active-high asynchronous reset.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            owner_q <= '0;
            wr_en_q <= 1'b0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            wr_en_q <= wr_en_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
        end
    end

    assign fifo_wr_en   = wr_en_q;
    assign fifo_data_in = data_q;
    assign owner        = owner_q;
    assign ovf_err      = ovf_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus a random run, checked by
// scoreboard queues drained by independent write monitors.
module tb_fifo_wr_arbiter;

    localparam int N     = 4;
    localparam int FW    = 16;
    localparam int MB    = 4;
    localparam int DEPTH = 8;
    localparam int PW    = 16384;
    localparam logic [3:0] RR_G [8] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [N-1:0]  req, gnt;
    logic [N*FW-1:0] req_data;
    logic          fifo_full, fifo_af, fifo_ovf, wr_en, ovf_err;
    logic [FW-1:0] data_out;
    logic [1:0]    owner;

    logic [N-1:0]  req_rr, gnt_rr;
    logic [N*FW-1:0] data_rr;
    logic          wr_rr, ovf_rr;
    logic [FW-1:0] dout_rr;
    logic [1:0]    owner_rr;

    fifo_wr_arbiter #(.N_REQ(N), .FIFO_WIDTH(FW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst), .req(req), .req_data(req_data), .gnt(gnt),
        .fifo_full(fifo_full), .fifo_almostfull(fifo_af), .fifo_overflow(fifo_ovf),
        .fifo_wr_en(wr_en), .fifo_data_in(data_out), .owner(owner), .ovf_err(ovf_err)
    );

    fifo_wr_arbiter #(.N_REQ(N), .FIFO_WIDTH(FW), .MAX_BURST(1)) dut_rr (
        .clk(clk), .rst_n(rst), .req(req_rr), .req_data(data_rr), .gnt(gnt_rr),
        .fifo_full(1'b0), .fifo_almostfull(1'b0), .fifo_overflow(1'b0),
        .fifo_wr_en(wr_rr), .fifo_data_in(dout_rr), .owner(owner_rr), .ovf_err(ovf_rr)
    );

    // FIFO occupancy model for the main DUT; depth 8, reads driven by the bench.
    int   fcnt = 0;
    int   fifo_preset = 0;
    logic rd_en = 1'b0;
    assign fifo_full = (fcnt == DEPTH);
    assign fifo_af   = (fcnt == DEPTH - 1);
    assign fifo_ovf  = wr_en && (fcnt == DEPTH);
    always @(posedge clk) begin
        if (rst) fcnt <= fifo_preset;
        else     fcnt <= fcnt + (wr_en ? 1 : 0) - ((rd_en && fcnt > 0) ? 1 : 0);
    end

    int checks = 0;
    int errors = 0;
    logic [FW-1:0] exp_q[$];
    logic [FW-1:0] exp_rr[$];
    logic [FW-1:0] pw [N][PW];
    int  pw_wr[N], pw_rd[N], seq[N], left[N], wait_cnt[N];
    bit  rand_mode = 1'b0;
    int  phase_wr = 0;
    int  rr_wr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [FW-1:0] word(input int i, input int s);
        logic [3:0]  id;
        logic [11:0] sq;
        id = i[3:0];
        sq = s[11:0];
        return {id, sq};
    endfunction

    task automatic set_word(input int i);
        req_data[i*FW +: FW] = word(i, seq[i]);
        if (rand_mode) begin
            pw[i][pw_wr[i] % PW] = word(i, seq[i]);
            pw_wr[i]++;
        end
    endtask

    task automatic start_prod(input int i, input int n);
        left[i]     = n;
        wait_cnt[i] = 0;
        set_word(i);
        req[i]      = 1'b1;
    endtask

    // One clock: optional grant check at negedge, then producer handshake after the edge.
    task automatic step(input logic [N-1:0] exp_g, input string name);
        logic [N-1:0] tr;
        @(negedge clk);
        if (name != "") chk(name, 32'(gnt), 32'(exp_g));
        tr = gnt & req;
        for (int i = 0; i < N; i++) begin
            if (tr[i]) begin
                chk("starve", 32'(wait_cnt[i] <= N*MB), 32'd1);
                wait_cnt[i] = 0;
            end else if (req[i] && tr != '0) begin
                wait_cnt[i]++;
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (tr[i]) begin
                seq[i]++;
                left[i]--;
                if (left[i] > 0) set_word(i);
                else req[i] = 1'b0;
            end
        end
    endtask

    task automatic do_reset(input int preset);
        rst = 1'b1;
        req = '0;
        req_rr = '0;
        rd_en = 1'b0;
        fifo_preset = preset;
        for (int i = 0; i < N; i++) begin
            seq[i] = 0; left[i] = 0; wait_cnt[i] = 0; pw_wr[i] = 0; pw_rd[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin : mon_main
        int id;
        if (!rst && wr_en) begin
            phase_wr++;
            if (rand_mode) begin
                id = int'(data_out[15:12]);
                if (id < N && pw_rd[id] < pw_wr[id]) begin
                    chk("rand_data", 32'(data_out), 32'(pw[id][pw_rd[id] % PW]));
                    pw_rd[id]++;
                end else begin
                    checks++; errors++;
                    $display("FAIL rand_unexp: got %0h expected none", data_out);
                end
            end else if (exp_q.size() > 0) begin
                chk("wr_data", 32'(data_out), 32'(exp_q.pop_front()));
            end else begin
                checks++; errors++;
                $display("FAIL wr_unexp: got %0h expected no write", data_out);
            end
        end
    end

    always @(negedge clk) begin : mon_rr
        if (!rst && wr_rr) begin
            rr_wr++;
            if (exp_rr.size() > 0) begin
                chk("rr_data", 32'(dout_rr), 32'(exp_rr.pop_front()));
            end else begin
                checks++; errors++;
                $display("FAIL rr_unexp: got %0h expected no write", dout_rr);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [N-1:0] g;
        rst = 1'b0; req = '0; req_data = '0; req_rr = '0; data_rr = '0;
        #2 rst = 1'b1;
        #1;
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_ovf", 32'(ovf_err), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);

        // Pure round-robin with MAX_BURST=1
        do_reset(0);
        exp_rr.push_back(16'h0000); exp_rr.push_back(16'h1000);
        exp_rr.push_back(16'h2000); exp_rr.push_back(16'h3000);
        exp_rr.push_back(16'h0001); exp_rr.push_back(16'h1001);
        exp_rr.push_back(16'h2001); exp_rr.push_back(16'h3001);
        data_rr = {16'h3000, 16'h2000, 16'h1000, 16'h0000};
        req_rr = 4'hF;
        rr_wr = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("rr_gnt", 32'(gnt_rr), 32'(RR_G[k]));
            g = gnt_rr;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (g[i]) data_rr[i*FW +: FW] = data_rr[i*FW +: FW] + 16'd1;
            end
        end
        req_rr = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rr_wr_cnt", 32'(rr_wr), 32'd8);
        chk("rr_drain", 32'(exp_rr.size()), 32'd0);

        // Bursts of four from producer 0 then producer 1
        do_reset(0);
        rd_en = 1'b1;
        phase_wr = 0;
        for (int s = 0; s < 4; s++) exp_q.push_back(16'h0000 + 16'(s));
        for (int s = 0; s < 4; s++) exp_q.push_back(16'h1000 + 16'(s));
        start_prod(0, 4);
        start_prod(1, 4);
        for (int k = 0; k < 4; k++) step(4'b0001, "burst_g0");
        for (int k = 0; k < 4; k++) step(4'b0010, "burst_g1");
        step(4'b0000, "burst_end");
        chk("burst_wr_cnt", 32'(phase_wr), 32'd8);
        chk("burst_owner", 32'(owner), 32'd1);
        chk("burst_drain", 32'(exp_q.size()), 32'd0);

        // Full throttle: depth 8, no reads
        do_reset(0);
        phase_wr = 0;
        for (int s = 0; s < 8; s++) exp_q.push_back(16'h0000 + 16'(s));
        start_prod(0, 20);
        for (int k = 0; k < 8; k++) step(4'b0001, "full_w");
        for (int k = 0; k < 3; k++) step(4'b0000, "full_blk");
        chk("full_wr_cnt", 32'(phase_wr), 32'd8);
        chk("full_fcnt", 32'(fcnt), 32'd8);
        chk("full_ovf", 32'(ovf_err), 32'd0);
        chk("full_drain", 32'(exp_q.size()), 32'd0);

        // Almostfull with a write in flight
        do_reset(6);
        phase_wr = 0;
        exp_q.push_back(16'h0000); exp_q.push_back(16'h0001); exp_q.push_back(16'h0002);
        start_prod(0, 4);
        step(4'b0001, "af_w0");
        step(4'b0001, "af_w1");
        step(4'b0000, "af_inflight");
        step(4'b0000, "af_full");
        rd_en = 1'b1;
        step(4'b0000, "af_full_rd");
        rd_en = 1'b0;
        step(4'b0001, "af_after_rd");
        step(4'b0000, "af_refull");
        step(4'b0000, "af_hold");
        chk("af_wr_cnt", 32'(phase_wr), 32'd3);
        chk("af_ovf", 32'(ovf_err), 32'd0);
        chk("af_drain", 32'(exp_q.size()), 32'd0);

        // Burst owner drops its request
        do_reset(0);
        rd_en = 1'b1;
        phase_wr = 0;
        exp_q.push_back(16'h2000); exp_q.push_back(16'h3000); exp_q.push_back(16'h0000);
        start_prod(2, 1);
        start_prod(3, 1);
        step(4'b0100, "drop_w2");
        chk("drop_owner", 32'(owner), 32'd2);
        step(4'b0000, "drop_nogrant");
        start_prod(0, 1);
        step(4'b1000, "drop_next3");
        step(4'b0000, "drop_own3");
        step(4'b0001, "drop_then0");
        step(4'b0000, "drop_idle");
        chk("drop_wr_cnt", 32'(phase_wr), 32'd3);
        chk("drop_drain", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a burst
        do_reset(0);
        rd_en = 1'b1;
        phase_wr = 0;
        exp_q.push_back(16'h1000);
        start_prod(1, 8);
        step(4'b0010, "rst_w0");
        step(4'b0010, "rst_w1");
        rst = 1'b1;
        #1;
        chk("midrst_wr_en", 32'(wr_en), 32'd0);
        chk("midrst_owner", 32'(owner), 32'd0);
        chk("midrst_gnt", 32'(gnt), 32'd0);
        chk("midrst_data", 32'(data_out), 32'd0);
        do_reset(0);
        rd_en = 1'b1;
        chk("midrst_wr_cnt", 32'(phase_wr), 32'd1);
        chk("midrst_drain", 32'(exp_q.size()), 32'd0);
        exp_q.push_back(16'h0000); exp_q.push_back(16'h1000);
        start_prod(1, 1);
        start_prod(0, 1);
        step(4'b0001, "rst_ptr");
        step(4'b0000, "");
        step(4'b0010, "rst_after");
        step(4'b0000, "");
        chk("rst_ptr_drain", 32'(exp_q.size()), 32'd0);

        // Random traffic with random reads
        do_reset(0);
        rand_mode = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            rd_en = ($urandom_range(0, 9) < 6);
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 3) == 0) start_prod(i, int'($urandom_range(1, 6)));
            end
            step(4'b0000, "");
        end
        rd_en = 1'b1;
        for (int c = 0; c < 300 && req != '0; c++) step(4'b0000, "");
        chk("rand_done", 32'(req), 32'd0);
        repeat (3) step(4'b0000, "");
        for (int i = 0; i < N; i++) chk("rand_consumed", 32'(pw_rd[i]), 32'(pw_wr[i]));
        chk("rand_ovf", 32'(ovf_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
